// File: rtl/raster_scan_gen_pkg.sv
// Shared types and fixed-point helpers for the raster coordinate source.
package raster_scan_gen_pkg;

  typedef logic signed [31:0] fp;

  localparam int unsigned FP_W        = 32;
  localparam int unsigned Q11_21_FRAC = 21;
  localparam int unsigned MAX_RES     = 1024;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  // Non-negative integer to fixed point with a configurable fractional width.
  function automatic fp to_fixed(input logic [FP_W-1:0] v, input int unsigned frac);
    return fp'(v << frac);
  endfunction

  function automatic fp int_to_q11_21(input logic [FP_W-1:0] v);
    return to_fixed(v, Q11_21_FRAC);
  endfunction

endpackage

// File: rtl/raster_scan_gen_counter.sv
// Raster position counters: x_base steps by LANES, wraps at line end, y wraps at frame end.
module raster_counter
  import raster_scan_gen_pkg::*;
#(
  parameter int unsigned H_RES = 640,
  parameter int unsigned V_RES = 480,
  parameter int unsigned LANES = 1,
  parameter int unsigned XW    = $clog2(H_RES + 1),
  parameter int unsigned YW    = $clog2(V_RES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [XW-1:0] x_next_c,
  output logic [YW-1:0] y_next_c,
  output logic          line_end_c,
  output logic          frame_end_c
);

  logic [XW-1:0] x_base;
  logic [YW-1:0] y;

  assign line_end_c  = (x_base == XW'(H_RES - LANES));
  assign frame_end_c = (y == YW'(V_RES - 1));

  // Next position, also consumed by the top to preload its output registers.
  always_comb begin
    x_next_c = x_base;
    y_next_c = y;
    if (clear) begin
      x_next_c = '0;
      y_next_c = '0;
    end else if (advance) begin
      if (line_end_c) begin
        x_next_c = '0;
        y_next_c = frame_end_c ? '0 : y + YW'(1);
      end else begin
        x_next_c = x_base + XW'(LANES);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_base <= '0;
      y      <= '0;
    end else begin
      x_base <= x_next_c;
      y      <= y_next_c;
    end
  end

endmodule

// File: rtl/raster_scan_gen.sv
// Raster-order pixel coordinate source with valid/ready output, LANES pixels per beat,
// single-shot or continuous frames and a graceful stop.
module raster_scan_gen
  import raster_scan_gen_pkg::*;
#(
  parameter int unsigned H_RES     = 640,
  parameter int unsigned V_RES     = 480,
  parameter int unsigned LANES     = 1,
  parameter int unsigned FRAC_BITS = Q11_21_FRAC,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  continuous,
  input  logic                  stop,
  input  logic                  ready_in,
  output logic                  valid_out,
  output logic [LANES*FP_W-1:0] screen_x,
  output logic [FP_W-1:0]       screen_y,
  output logic                  sof,
  output logic                  eol,
  output logic                  busy,
  output logic                  frame_done,
  output logic [CNT_W-1:0]      frame_count
);

  localparam int unsigned XW = $clog2(H_RES + 1);
  localparam int unsigned YW = $clog2(V_RES + 1);

  if (H_RES % LANES != 0) begin : g_bad_lanes
    $error("raster_scan_gen: H_RES must be a multiple of LANES");
  end
  if (H_RES > MAX_RES || V_RES > MAX_RES) begin : g_bad_res
    $error("raster_scan_gen: resolution exceeds 1024");
  end

  scan_state_e state_q, state_d;

  logic                  mode_cont, mode_cont_d;
  logic                  stop_pending, stop_pending_d;
  logic                  valid_d, busy_d, sof_d, eol_d, frame_done_d;
  logic [LANES*FP_W-1:0] screen_x_d;
  logic [FP_W-1:0]       screen_y_d;
  logic [CNT_W-1:0]      frame_count_d;

  logic          xfer_c, accept_c, last_c, restart_c, load_c;
  logic [XW-1:0] x_next_c;
  logic [YW-1:0] y_next_c;
  logic          line_end_c, frame_end_c;

  assign xfer_c    = valid_out & ready_in;
  assign accept_c  = (state_q == ST_IDLE) & start;
  assign last_c    = xfer_c & line_end_c & frame_end_c;
  assign restart_c = mode_cont & ~stop_pending & ~stop;

  raster_counter #(
    .H_RES(H_RES),
    .V_RES(V_RES),
    .LANES(LANES),
    .XW   (XW),
    .YW   (YW)
  ) u_counter (
    .clk        (clk),
    .rst        (rst),
    .clear      (accept_c),
    .advance    (xfer_c),
    .x_next_c   (x_next_c),
    .y_next_c   (y_next_c),
    .line_end_c (line_end_c),
    .frame_end_c(frame_end_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_SCAN;
      ST_SCAN: if (last_c && !restart_c) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output registers reload on frame start and on every transfer that keeps the scan going.
  assign load_c = accept_c | (xfer_c & (state_d == ST_SCAN));

  always_comb begin
    valid_d        = (state_d == ST_SCAN);
    busy_d         = (state_d != ST_IDLE);
    screen_x_d     = screen_x;
    screen_y_d     = screen_y;
    sof_d          = sof;
    eol_d          = eol;
    frame_done_d   = last_c;
    frame_count_d  = last_c ? frame_count + CNT_W'(1) : frame_count;
    mode_cont_d    = mode_cont;
    stop_pending_d = stop_pending;
    if (load_c) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        screen_x_d[k*FP_W +: FP_W] = to_fixed(FP_W'(x_next_c) + FP_W'(k), FRAC_BITS);
      end
      screen_y_d = to_fixed(FP_W'(y_next_c), FRAC_BITS);
      sof_d      = (x_next_c == '0) && (y_next_c == '0);
      eol_d      = (x_next_c == XW'(H_RES - LANES));
    end
    if (accept_c || (last_c && restart_c)) mode_cont_d = continuous;
    if (state_d == ST_IDLE)                 stop_pending_d = 1'b0;
    else if (state_q == ST_SCAN && stop)    stop_pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out    <= 1'b0;
      busy         <= 1'b0;
      screen_x     <= '0;
      screen_y     <= '0;
      sof          <= 1'b0;
      eol          <= 1'b0;
      frame_done   <= 1'b0;
      frame_count  <= '0;
      mode_cont    <= 1'b0;
      stop_pending <= 1'b0;
    end else begin
      valid_out    <= valid_d;
      busy         <= busy_d;
      screen_x     <= screen_x_d;
      screen_y     <= screen_y_d;
      sof          <= sof_d;
      eol          <= eol_d;
      frame_done   <= frame_done_d;
      frame_count  <= frame_count_d;
      mode_cont    <= mode_cont_d;
      stop_pending <= stop_pending_d;
    end
  end

endmodule
